// File: rtl/gate_truth_checker.sv
// Clocked stimulus/response checker for a 2-input combinational gate: walks the
// four input vectors, samples the gate after a settle window and scores it.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       gate_in1_o,
    output logic       gate_in2_o,
    input  logic       gate_out_i,
    output logic [1:0] vec_idx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [2:0] err_count_o,
    output logic [3:0] err_mask_o
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned VEC_W = 2;
    localparam int unsigned ERR_W = 3;
    localparam int unsigned NVEC  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NVEC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VEC_W-1:0]  vec_idx_q, vec_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [NVEC-1:0]   err_mask_q, err_mask_d;
    logic              mismatch_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_idx_q   <= vec_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
        end
    end

    // Next-state: start accepted only when not mid-run; score on the last settle cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_idx_d   = vec_idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;
        mismatch_c  = (gate_out_i != EXPECTED[vec_idx_q]);

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d     = SETTLE;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    vec_idx_d   = '0;
                    cnt_d       = '0;
                    err_count_d = '0;
                    err_mask_d  = '0;
                end
            end
            SETTLE: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    if (mismatch_c) begin
                        err_count_d            = err_count_q + ERR_W'(1);
                        err_mask_d[vec_idx_q]  = 1'b1;
                    end
                    if (vec_idx_q == VEC_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_d == '0);
                    end else begin
                        vec_idx_d = vec_idx_q + VEC_W'(1);
                        cnt_d     = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gate_in1_o  = vec_idx_q[1];
    assign gate_in2_o  = vec_idx_q[0];
    assign vec_idx_o   = vec_idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_count_q;
    assign err_mask_o  = err_mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (default and single-cycle settle)
// each driving a table-defined gate, scored against a vector-count model.
module tb_gate_truth_checker;

    localparam int unsigned S_A   = 2;
    localparam logic [3:0]  EXP_A = 4'b1000;
    localparam int unsigned S_B   = 1;
    localparam logic [3:0]  EXP_B = 4'b1110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [3:0] tt_a = 4'b1000, tt_b = 4'b1000;

    logic       in1_a, in2_a, gout_a, busy_a, done_a, pass_a;
    logic [1:0] vec_a;
    logic [2:0] cnt_a;
    logic [3:0] mask_a;
    logic       in1_b, in2_b, gout_b, busy_b, done_b, pass_b;
    logic [1:0] vec_b;
    logic [2:0] cnt_b;
    logic [3:0] mask_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign gout_a = tt_a[{in1_a, in2_a}];
    assign gout_b = tt_b[{in1_b, in2_b}];

    gate_truth_checker #(.SETTLE_CYCLES(S_A), .EXPECTED(EXP_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .gate_in1_o(in1_a), .gate_in2_o(in2_a), .gate_out_i(gout_a),
        .vec_idx_o(vec_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .err_count_o(cnt_a), .err_mask_o(mask_a)
    );

    gate_truth_checker #(.SETTLE_CYCLES(S_B), .EXPECTED(EXP_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .gate_in1_o(in1_b), .gate_in2_o(in2_b), .gate_out_i(gout_b),
        .vec_idx_o(vec_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .err_count_o(cnt_b), .err_mask_o(mask_b)
    );

    logic [13:0] obs_a, obs_b;
    assign obs_a = {in1_a, in2_a, vec_a, busy_a, done_a, pass_a, cnt_a, mask_a};
    assign obs_b = {in1_b, in2_b, vec_b, busy_b, done_b, pass_b, cnt_b, mask_b};

    // Expected outputs k edges after the accepting edge: vectors fully sampled so far
    // are k/s, and a vector is bad wherever the gate table differs from EXPECTED.
    function automatic logic [13:0] model(input int s, input logic [3:0] exp_tt,
                                          input logic [3:0] tt, input int k);
        int n;
        logic [1:0] v;
        logic [3:0] bad, seen;
        logic busy, done, pass;
        n    = (k / s > 4) ? 4 : k / s;
        v    = (k < 4 * s) ? 2'(k / s) : 2'd3;
        seen = 4'((1 << n) - 1);
        bad  = (tt ^ exp_tt) & seen;
        busy = (k < 4 * s);
        done = (k >= 4 * s);
        pass = done && (bad == 4'b0000);
        return {v[1], v[0], v, busy, done, pass, 3'($countones(bad)), bad};
    endfunction

    task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    // One full run on instance sel; optionally leaves start held high at the end.
    task automatic run(input int sel, input logic [3:0] tt, input bit hold_at_end);
        int s;
        logic [3:0] e;
        s = (sel == 0) ? S_A : S_B;
        e = (sel == 0) ? EXP_A : EXP_B;
        if (sel == 0) tt_a = tt; else tt_b = tt;
        start_a = (sel == 0);
        start_b = (sel == 1);
        for (int k = 0; k <= 4 * s; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("dut%0d tt=%b k=%0d", sel, tt, k),
                (sel == 0) ? obs_a : obs_b, model(s, e, tt, k));
            if (k < 4 * s) set_start(sel, (k == 2) ? 1'b1 : 1'($urandom % 2));
            else           set_start(sel, hold_at_end);
        end
        if (!hold_at_end) begin
            for (int k = 4 * s + 1; k <= 4 * s + 2; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("dut%0d hold tt=%b k=%0d", sel, tt, k),
                    (sel == 0) ? obs_a : obs_b, model(s, e, tt, k));
            end
        end
    endtask

    initial begin
        #1;
        chk("reset_a", obs_a, 14'd0);
        chk("reset_b", obs_b, 14'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_a", obs_a, 14'd0);
        chk("idle_b", obs_b, 14'd0);

        run(0, 4'b1000, 1'b0);   // correct AND
        run(0, 4'b0000, 1'b0);   // stuck-at-0
        run(0, 4'b1110, 1'b0);   // OR against AND table
        run(1, 4'b1000, 1'b0);   // AND against OR table, 1-cycle settle
        run(1, 4'b1110, 1'b0);   // OR against OR table
        run(0, 4'b0000, 1'b1);   // failing run, start held into restart
        run(0, 4'b1000, 1'b0);   // swapped-in correct gate

        // Reset mid-run aborts at once and clears everything.
        tt_a = 4'b0000;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_a", obs_a, 14'd0);
        chk("midrst_b", obs_b, 14'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold_a", obs_a, 14'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_idle_a", obs_a, 14'd0);
        run(0, 4'b1000, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run(int'($urandom % 2), 4'($urandom % 16), 1'($urandom % 2));
        end
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
